// File: rtl/fc_1.sv
// Fully connected layer: streams N_IN signed pixels and multiply-accumulates each one
// against a row of N_OUT weights fetched from external memory, then presents the result vector.
module fc_1 #(
    parameter int BITWIDTH = 32,
    parameter int N_IN     = 392,
    parameter int N_OUT    = 10,
    parameter int AW       = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITWIDTH-1:0]       in_data,
    output logic                      w_en,
    output logic [AW-1:0]             w_addr,
    input  logic [N_OUT*BITWIDTH-1:0] w_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*BITWIDTH-1:0] out_data
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    state_t                      state;
    logic [AW-1:0]               cnt;
    logic                        s2v;
    logic signed [BITWIDTH-1:0]  pix_q;
    logic signed [BITWIDTH-1:0]  acc  [N_OUT];
    logic signed [BITWIDTH-1:0]  prod [N_OUT];
    logic                        accept;
    logic                        release_result;

    assign in_ready       = (state == RUN);
    assign accept         = in_valid && in_ready;
    assign w_en           = accept;
    assign w_addr         = cnt;
    assign out_valid      = (state == DONE);
    assign release_result = (state == DONE) && out_ready;

    // The weight row arrives one cycle after its address, so the pixel is held
    // in pix_q for that cycle and the MAC runs as the second pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            s2v   <= 1'b0;
            pix_q <= '0;
        end else begin
            s2v <= accept;
            if (accept) begin
                pix_q <= in_data;
                cnt   <= cnt + AW'(1);
            end
            case (state)
                RUN: begin
                    if (accept && cnt == LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= RUN;
                        cnt   <= '0;
                        s2v   <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Products keep only their low BITWIDTH bits, so the sums wrap naturally.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            prod[n] = pix_q * $signed(w_data[n*BITWIDTH +: BITWIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_OUT; n++) begin
                acc[n] <= '0;
            end
        end else if (release_result) begin
            for (int n = 0; n < N_OUT; n++) begin
                acc[n] <= '0;
            end
        end else if (s2v) begin
            for (int n = 0; n < N_OUT; n++) begin
                acc[n] <= acc[n] + prod[n];
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pack
        assign out_data[g*BITWIDTH +: BITWIDTH] = acc[g];
    end

endmodule

// File: tb/tb_fc_1.sv
// Testbench for fc_1: drives randomized pixel streams against a weight-memory model
// and compares each result vector with a sum-of-products reference.
module tb_fc_1;

    localparam int BW    = 32;
    localparam int N_IN  = 392;
    localparam int N_OUT = 10;
    localparam int AW    = 9;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [BW-1:0]          in_data;
    logic                   w_en;
    logic [AW-1:0]          w_addr;
    logic [N_OUT*BW-1:0]    w_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_OUT*BW-1:0]    out_data;

    int                     checks;
    int                     failures;
    int                     pix  [N_IN];
    logic [N_OUT*BW-1:0]    wrow [N_IN];
    int                     addr_q [$];
    int                     beats_fed;

    fc_1 #(.BITWIDTH(BW), .N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (w_en) w_data <= wrow[w_addr];
    end

    // Reference: each lane is the dot product of the pixel vector and that lane's weight column, mod 2^32.
    function automatic logic [N_OUT*BW-1:0] model_result();
        int                  a [N_OUT];
        logic [N_OUT*BW-1:0] r;
        logic [N_OUT*BW-1:0] row;
        for (int n = 0; n < N_OUT; n++) a[n] = 0;
        for (int k = 0; k < N_IN; k++) begin
            row = wrow[k];
            for (int n = 0; n < N_OUT; n++) a[n] += pix[k] * int'(row[n*BW +: BW]);
        end
        for (int n = 0; n < N_OUT; n++) r[n*BW +: BW] = a[n];
        return r;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < N_IN; k++) begin
            pix[k] = $urandom;
            for (int n = 0; n < N_OUT; n++) wrow[k][n*BW +: BW] = $urandom;
        end
    endtask

    // Drives n_beats pixels with roughly gap_pct percent idle cycles, logging every strobed address.
    task automatic feed_frame(input int gap_pct, input int n_beats);
        int   idx;
        int   cyc;
        logic v;
        logic took;
        idx = 0;
        cyc = 0;
        addr_q.delete();
        while (idx < n_beats && cyc < 20000) begin
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? pix[idx] : $urandom;
            @(negedge clk);
            if (w_en) addr_q.push_back(int'(w_addr));
            took = v && in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        beats_fed = idx;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        w_data    = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (w_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_w_en got=%b exp=0", w_en);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("[TB] FAIL post_reset_out_data got=%h exp=0", out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lead_in();
        int lat;
        for (int k = 0; k < N_IN; k++) begin
            pix[k] = 0;
            for (int n = 0; n < N_OUT; n++) wrow[k][n*BW +: BW] = n + 1;
        end
        pix[0] = 1; pix[1] = 2; pix[2] = 3; pix[3] = 1145;
        feed_frame(0, N_IN);
        wait_out(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL lead_in_latency got=%0d exp=2", lat);
        end
        for (int n = 0; n < N_OUT; n++) begin
            checks++;
            if ($signed(out_data[n*BW +: BW]) !== 1151 * (n + 1)) begin
                failures++;
                $display("[TB] FAIL lead_in_lane%0d got=%0d exp=%0d", n, $signed(out_data[n*BW +: BW]), 1151 * (n + 1));
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL lead_in_release got=v%b r%b d%h exp=v0 r1 d0", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_gaps();
        int lat;
        int bad_addr;
        for (int k = 0; k < N_IN; k++) begin
            pix[k] = -1;
            for (int n = 0; n < N_OUT; n++) wrow[k][n*BW +: BW] = 2;
        end
        feed_frame(50, N_IN);
        bad_addr = (addr_q.size() == N_IN) ? 0 : 1;
        foreach (addr_q[i]) if (addr_q[i] != i) bad_addr++;
        checks++;
        if (bad_addr != 0) begin
            failures++;
            $display("[TB] FAIL gaps_addr_seq got=%0d_addrs/%0d_bad exp=%0d/0", addr_q.size(), bad_addr, N_IN);
        end
        wait_out(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL gaps_latency got=%0d exp=2", lat);
        end
        for (int n = 0; n < N_OUT; n++) begin
            checks++;
            if ($signed(out_data[n*BW +: BW]) !== -784) begin
                failures++;
                $display("[TB] FAIL gaps_lane%0d got=%0d exp=-784", n, $signed(out_data[n*BW +: BW]));
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int                  lat;
        int                  bad;
        logic [N_OUT*BW-1:0] exp_v;
        logic [N_OUT*BW-1:0] snap;
        fill_random();
        exp_v = model_result();
        feed_frame(20, N_IN);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
            failures++;
            $display("[TB] FAIL bp_result got=v%b %h exp=v1 %h", out_valid, out_data, exp_v);
        end
        snap = exp_v;
        bad = 0;
        in_valid = 1'b1;
        repeat (20) begin
            in_data = $urandom;
            @(negedge clk);
            if (in_ready !== 1'b0 || w_en !== 1'b0 || out_valid !== 1'b1 || out_data !== snap) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL bp_hold got=%0d_bad_cycles exp=0", bad);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL bp_release got=v%b r%b d%h exp=v0 r1 d0", out_valid, in_ready, out_data);
        end
        fill_random();
        exp_v = model_result();
        feed_frame(10, N_IN);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
            failures++;
            $display("[TB] FAIL bp_next_frame got=%h exp=%h", out_data, exp_v);
        end
        handshake();
    endtask

    task automatic test_overflow();
        int lat;
        for (int k = 0; k < N_IN; k++) begin
            pix[k]  = 0;
            wrow[k] = '0;
        end
        pix[0]        = 32'h7FFF_FFFF;
        wrow[0][31:0] = 32'd2;
        feed_frame(0, N_IN);
        wait_out(lat);
        checks++;
        if (out_data[31:0] !== 32'hFFFF_FFFE || out_data[N_OUT*BW-1:BW] !== '0) begin
            failures++;
            $display("[TB] FAIL overflow_wrap got=%h exp=lane0 fffffffe rest 0", out_data);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        int                  lat;
        logic [N_OUT*BW-1:0] exp_v;
        fill_random();
        feed_frame(30, 200);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_clear got=v%b r%b d%h exp=v0 r1 d0", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_random();
        exp_v = model_result();
        feed_frame(25, N_IN);
        checks++;
        if (addr_q.size() < 1 || addr_q[0] != 0) begin
            failures++;
            $display("[TB] FAIL mid_reset_first_addr got=%0d exp=0", addr_q.size() > 0 ? addr_q[0] : -1);
        end
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
            failures++;
            $display("[TB] FAIL mid_reset_frame got=%h exp=%h", out_data, exp_v);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [N_OUT*BW-1:0] exp_v;
        int                  hs;
        logic [N_OUT*BW-1:0] got;
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            exp_v = model_result();
            feed_frame(0, N_IN);
            hs  = 0;
            got = '0;
            repeat (10) begin
                @(negedge clk);
                if (out_valid && out_ready) begin
                    hs++;
                    got = out_data;
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (hs != 1) begin
                failures++;
                $display("[TB] FAIL b2b_handshakes frame%0d got=%0d exp=1", f, hs);
            end
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("[TB] FAIL b2b_result frame%0d got=%h exp=%h", f, got, exp_v);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lead_in();
        test_gaps();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_1.md
FC_1 -- requirements
Module: fc_1

Interface
REQ-001 Parameter: BITWIDTH, default 32, width of every pixel, weight and accumulator lane.
REQ-002 Parameter: N_IN, default 392, flattened input length (2 channels x 14 x 14 pooled map).
REQ-003 Parameter: N_OUT, default 10, number of output neurons.
REQ-004 Parameter: AW, default 9, weight address width, equal to ceil(log2(N_IN)).
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: in_valid  input  1  in_data holds a valid pooled pixel.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: in_data  input  BITWIDTH  signed pooled pixel; order is channel, row, column, raster.
REQ-010 Port: w_en  output  1  weight-memory read strobe.
REQ-011 Port: w_addr  output  AW  weight row index (= input pixel index).
REQ-012 Port: w_data  input  N_OUT*BITWIDTH  signed weights; lane n holds bits [n*BITWIDTH +: BITWIDTH]; valid exactly one cycle after the w_en cycle.
REQ-013 Port: out_valid  output  1  out_data holds a complete result vector.
REQ-014 Port: out_ready  input  1  consumer accepts out_data.
REQ-015 Port: out_data  output  N_OUT*BITWIDTH  signed accumulators, lane packing as REQ-012.

Function
REQ-016 States SHALL be RUN, DRAIN and DONE.
REQ-017 An input beat is accepted when in_valid and in_ready are both high.
REQ-018 In RUN, in_ready SHALL be 1; in DRAIN and DONE, in_ready SHALL be 0.
REQ-019 w_en SHALL equal in_valid AND in_ready, combinationally.
REQ-020 w_addr SHALL equal the accept counter cnt, combinationally.
REQ-021 On accept, in_data SHALL be registered into pix_q, stage-2 valid s2v SHALL be set to 1, and cnt SHALL increment.
REQ-022 A cycle with no accept SHALL clear s2v to 0 (bubble); bubbles SHALL NOT alter the accumulators.
REQ-023 When s2v is 1, each lane n SHALL update acc[n] <= acc[n] + pix_q * w_data lane n.
REQ-024 Each product SHALL be signed BITWIDTH x BITWIDTH, truncated to its low BITWIDTH bits; accumulation SHALL wrap modulo 2^BITWIDTH with no saturation.
REQ-025 Accepting the beat with cnt = N_IN-1 SHALL move the state RUN -> DRAIN.
REQ-026 DRAIN SHALL last exactly one cycle, performing the final MAC, then move to DONE.
REQ-027 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until the handshake completes.
REQ-028 On out_valid and out_ready in DONE, the block SHALL:
- clear all acc[n], cnt and s2v to 0;
- move to RUN, so the next frame may be accepted the following cycle.
REQ-029 out_data SHALL be driven directly from acc[]; out_valid SHALL be 0 outside DONE.
REQ-030 in_valid while in_ready is 0 SHALL be ignored; in_data need not be held stable by the block.
REQ-031 Latency from the last accepted beat to out_valid SHALL be 2 cycles; sustained throughput SHALL be 1 beat per cycle.
REQ-032 out_ready held high continuously SHALL cause a single handshake per frame.

Reset
REQ-033 Assertion of rst SHALL immediately force the following, regardless of clock:
- state = RUN, cnt = 0, s2v = 0, all acc = 0;
- out_valid = 0, in_ready = 1 once released.
REQ-034 rst asserted mid-frame or in DONE SHALL discard the partial or pending result with no output handshake.

Verification
REQ-035 Reset check: assert rst, then release -> out_valid = 0, in_ready = 1, w_en = 0, out_data all zero.
REQ-036 Frame with a lead-in of valid values, then zeros:
- stimulus: pixels 1, 2, 3, 1145 at indices 0-3, zeros elsewhere; weight row k lane n = n+1;
- response: lane n = 1151*(n+1); out_valid exactly 2 cycles after beat 391.
REQ-037 Random in_valid gaps (≈50%) over a full frame, all pixels = -1, all weights = 2:
- response: every lane = -784;
- w_addr sequence 0..391 with no skips or repeats.
REQ-038 Backpressure:
- stimulus: out_ready low for 20 cycles in DONE while in_valid stays high;
- response: in_ready = 0, out_data unchanged, no w_en;
- then out_ready high for 1 cycle -> RUN, and the next frame starts from zero.
REQ-039 Overflow wrap: pixel 0 = 0x7FFFFFFF with weight 2 in lane 0, rest zero -> lane 0 = 0xFFFFFFFE.
REQ-040 rst pulse after 200 accepted beats -> cnt = 0 and acc cleared; a following full frame yields a result identical to a clean run.
